keypad_cipher_array: RTL

- Parametrised successor of the 4-digit keypad encrypt/decrypt path.
- Captures a DEPTH-digit word and a DEPTH-digit key from a 0-9/*/# keypad, then computes a per-digit cipher and its inverse serially, one digit per cycle.
- Time-multiplexes the result onto a 2*DEPTH-position 7-segment display via common select lines.
- Sits between keypad debounce logic and the BinaryToSegment decoder.

---
 rtl/keypad_cipher_array.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_cipher_array.sv
// Keypad word/key capture with a serial per-digit cipher and a multiplexed 2*DEPTH-position display.
// Define XOR_CIPHER_EN to swap the mod-10 add/subtract cipher for a bitwise XOR cipher.
module keypad_cipher_array #(
    parameter int DEPTH    = 4,
    parameter int DW       = 4,
    parameter int SCAN_DIV = 1024,
    localparam int PW      = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           num,
    input  logic                 star,
    input  logic                 sharp,
    output logic [2*DEPTH-1:0]   com,
    output logic [DW-1:0]        seg_val,
    output logic [1:0]           mode,
    output logic [PW-1:0]        wptr,
    output logic                 full,
    output logic                 busy
);
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PSW  = $clog2(2 * DEPTH);
    localparam int DIVW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] BLANK = {DW{1'b1}};
`ifndef XOR_CIPHER_EN
    localparam logic [DW:0] TEN = (DW + 1)'(10);
`endif

    typedef enum logic [1:0] {
        ST_WORD = 2'd0,
        ST_KEY  = 2'd1,
        ST_CALC = 2'd2,
        ST_SHOW = 2'd3
    } mode_e;

    mode_e              mode_r;
    logic [PW-1:0]      wptr_r;
    logic [IW-1:0]      idx_r;
    logic               full_r;
    logic               busy_r;
    logic [9:0]         num_q;
    logic               star_q;
    logic               sharp_q;
    logic [DW-1:0]      word_r [DEPTH];
    logic [DW-1:0]      key_r  [DEPTH];
    logic [DW-1:0]      enc_r  [DEPTH];
    logic [DW-1:0]      dec_r  [DEPTH];
    logic [DIVW-1:0]    div_r;
    logic [PSW-1:0]     pos_r;
    logic [2*DEPTH-1:0] com_r;
    logic [DW-1:0]      seg_r;

    logic               star_ev_s;
    logic               sharp_ev_s;
    logic               digit_ev_s;
    logic [DW-1:0]      digit_s;
    logic [2*DEPTH-1:0] com_s;
    logic [DW-1:0]      seg_s;
    logic               lower_s;
    logic [IW-1:0]      didx_s;

    // Returns {enc, dec}; a blank operand blanks both results.
    function automatic logic [2*DW-1:0] cipher(input logic [DW-1:0] w, input logic [DW-1:0] k);
        logic [DW-1:0] e;
        logic [DW-1:0] d;
`ifndef XOR_CIPHER_EN
        logic [DW:0]   s;
`endif
        if (w == BLANK || k == BLANK) begin
            e = BLANK;
            d = BLANK;
        end else begin
`ifdef XOR_CIPHER_EN
            e = w ^ k;
            d = e ^ k;
`else
            s = {1'b0, w} + {1'b0, k};
            e = (s >= TEN) ? DW'(s - TEN) : DW'(s);
            d = (e >= k) ? (e - k) : DW'({1'b0, e} + TEN - {1'b0, k});
`endif
        end
        return {e, d};
    endfunction

    assign star_ev_s  = star & ~star_q;
    assign sharp_ev_s = sharp & ~sharp_q;
    // A digit counts only when it is the sole key held and it was not held last cycle.
    assign digit_ev_s = $onehot(num) && ((num & num_q) == 10'd0) && !star_ev_s && !sharp_ev_s;

    // Encode the single held digit key into its value.
    always_comb begin
        digit_s = {DW{1'b0}};
        for (int k = 0; k < 10; k++) begin
            if (num[k]) begin
                digit_s = DW'(k);
            end else begin
                digit_s = digit_s;
            end
        end
    end

    // Mode FSM, digit buffers and the serial cipher pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r  <= ST_WORD;
            wptr_r  <= {PW{1'b0}};
            idx_r   <= {IW{1'b0}};
            full_r  <= 1'b0;
            busy_r  <= 1'b0;
            num_q   <= 10'd0;
            star_q  <= 1'b0;
            sharp_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                word_r[i] <= BLANK;
                key_r[i]  <= BLANK;
                enc_r[i]  <= BLANK;
                dec_r[i]  <= BLANK;
            end
        end else begin
            num_q   <= num;
            star_q  <= star;
            sharp_q <= sharp;
            case (mode_r)
                ST_WORD, ST_KEY: begin
                    if (sharp_ev_s) begin
                        wptr_r <= {PW{1'b0}};
                        full_r <= 1'b0;
                        for (int i = 0; i < DEPTH; i++) begin
                            if (mode_r == ST_WORD) word_r[i] <= BLANK;
                            else                   key_r[i]  <= BLANK;
                        end
                    end else if (star_ev_s) begin
                        wptr_r <= {PW{1'b0}};
                        full_r <= 1'b0;
                        if (mode_r == ST_WORD) begin
                            mode_r <= ST_KEY;
                        end else begin
                            mode_r <= ST_CALC;
                            idx_r  <= {IW{1'b0}};
                            busy_r <= 1'b1;
                        end
                    end else if (digit_ev_s && !full_r) begin
                        if (mode_r == ST_WORD) word_r[IW'(wptr_r)] <= digit_s;
                        else                   key_r[IW'(wptr_r)]  <= digit_s;
                        wptr_r <= wptr_r + PW'(1);
                        full_r <= (wptr_r == PW'(DEPTH - 1));
                    end else begin
                        wptr_r <= wptr_r;
                    end
                end
                ST_CALC: begin
                    {enc_r[idx_r], dec_r[idx_r]} <= cipher(word_r[idx_r], key_r[idx_r]);
                    if (idx_r == IW'(DEPTH - 1)) begin
                        mode_r <= ST_SHOW;
                        busy_r <= 1'b0;
                        idx_r  <= {IW{1'b0}};
                    end else begin
                        idx_r  <= idx_r + IW'(1);
                    end
                end
                ST_SHOW: begin
                    if (sharp_ev_s || star_ev_s) begin
                        mode_r <= ST_WORD;
                        wptr_r <= {PW{1'b0}};
                        for (int i = 0; i < DEPTH; i++) begin
                            word_r[i] <= BLANK;
                            key_r[i]  <= BLANK;
                            enc_r[i]  <= BLANK;
                            dec_r[i]  <= BLANK;
                        end
                    end else begin
                        mode_r <= ST_SHOW;
                    end
                end
                default: begin
                    mode_r <= ST_WORD;
                end
            endcase
        end
    end

    // Select what the current scan position displays in each mode.
    always_comb begin
        com_s   = {2*DEPTH{1'b1}};
        seg_s   = BLANK;
        lower_s = (pos_r < PSW'(DEPTH));
        didx_s  = lower_s ? IW'(pos_r) : IW'(pos_r - PSW'(DEPTH));
        case (mode_r)
            ST_WORD: begin
                if (lower_s) begin
                    com_s[pos_r] = 1'b0;
                    seg_s        = word_r[didx_s];
                end else begin
                    seg_s        = BLANK;
                end
            end
            ST_KEY: begin
                if (lower_s) begin
                    com_s[pos_r] = 1'b0;
                    seg_s        = key_r[didx_s];
                end else begin
                    seg_s        = BLANK;
                end
            end
            ST_SHOW: begin
                com_s[pos_r] = 1'b0;
                seg_s        = lower_s ? enc_r[didx_s] : dec_r[didx_s];
            end
            default: begin
                seg_s = BLANK;
            end
        endcase
    end

    // Scan divider, position counter and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= {DIVW{1'b0}};
            pos_r <= {PSW{1'b0}};
            com_r <= {2*DEPTH{1'b1}};
            seg_r <= BLANK;
        end else begin
            if (div_r == DIVW'(SCAN_DIV - 1)) begin
                div_r <= {DIVW{1'b0}};
                pos_r <= (pos_r == PSW'(2 * DEPTH - 1)) ? {PSW{1'b0}} : pos_r + PSW'(1);
            end else begin
                div_r <= div_r + DIVW'(1);
            end
            com_r <= com_s;
            seg_r <= seg_s;
        end
    end

    assign com     = com_r;
    assign seg_val = seg_r;
    assign mode    = mode_r;
    assign wptr    = wptr_r;
    assign full    = full_r;
    assign busy    = busy_r;

endmodule
